// File: rtl/axis_sc_fifo.sv
// Single-clock AXI-Stream FIFO with registered FWFT output, write-to-output bypass
// and registered fill-level flags for flow control.
module axis_sc_fifo #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEEP         = 32,
    parameter int unsigned DEEP_BITS    = $clog2(DEEP),
    parameter int unsigned ALMOST_FULL  = DEEP - 4,
    parameter int unsigned ALMOST_EMPTY = 4,
    parameter int unsigned ULTRA_SCALE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     s_rx_tdata,
    input  logic                 s_rx_tvalid,
    output logic                 s_rx_tready,
    output logic [WIDTH-1:0]     m_tx_tdata,
    output logic                 m_tx_tvalid,
    input  logic                 m_tx_tready,
    output logic [DEEP_BITS:0]   fifo_used,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam int unsigned PW = DEEP_BITS + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    used_q, used_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             s_ready_q, s_ready_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;

    logic             push, pop, ram_empty, out_free, ram_we;
    logic [PW-1:0]    ram_count;
    logic [WIDTH-1:0] ram_rdata;

    // RAM only ever holds DEEP-1 beats: the output register is always filled first.
    if (ULTRA_SCALE != 0) begin : g_uram
        (* ram_style = "ultra" *) logic [WIDTH-1:0] mem [DEEP];
        always_ff @(posedge clk) begin
            if (ram_we) mem[wr_ptr_q[DEEP_BITS-1:0]] <= s_rx_tdata;
        end
        assign ram_rdata = mem[rd_ptr_q[DEEP_BITS-1:0]];
    end else begin : g_lutram
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEEP];
        always_ff @(posedge clk) begin
            if (ram_we) mem[wr_ptr_q[DEEP_BITS-1:0]] <= s_rx_tdata;
        end
        assign ram_rdata = mem[rd_ptr_q[DEEP_BITS-1:0]];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ram_we      = 1'b0;

        push      = s_rx_tvalid & s_ready_q;
        pop       = out_valid_q & m_tx_tready;
        ram_count = wr_ptr_q - rd_ptr_q;
        ram_empty = (ram_count == '0);
        out_free  = ~out_valid_q | pop;

        // Output register refill: RAM head first, else bypass the incoming beat.
        if (out_free && !ram_empty) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end else if (out_free && push) begin
            out_valid_d = 1'b1;
            out_data_d  = s_rx_tdata;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (push && !(out_free && ram_empty)) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        used_d    = used_q + PW'(push) - PW'(pop);
        s_ready_d = (used_d < PW'(DEEP));
        afull_d   = (used_d >= PW'(ALMOST_FULL));
        aempty_d  = (used_d <= PW'(ALMOST_EMPTY));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            out_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            out_valid_q <= out_valid_d;
            s_ready_q   <= s_ready_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
        end
    end

    // Data path register carries no reset; its content is qualified by out_valid_q.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign s_rx_tready  = s_ready_q;
    assign m_tx_tdata   = out_data_q;
    assign m_tx_tvalid  = out_valid_q;
    assign fifo_used    = used_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule
